memory_read_ctrl: RTL

//  Egress counterpart of the packet-buffer write path. Takes frame descriptors {head block idx, byte length}
//  and walks the linked block chain via each footer's next_idx, streaming payload out 1 byte/beat.

---
 rtl/memory_read_ctrl_if.sv | 56 +++++
 rtl/memory_read_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/memory_read_ctrl_if.sv
// Packet-memory block layout shared by the egress path, and the bundled ports of
// memory_read_ctrl (descriptor, memory read, byte stream, free-list return, error).
package mem_pkg;
  localparam int ADDR_W        = 15;
  localparam int BLOCK_BYTES   = 64;
  localparam int PAYLOAD_BYTES = 62;
  localparam int BLOCK_BITS    = BLOCK_BYTES * 8;

  typedef struct packed {
    logic              eop;
    logic [ADDR_W-1:0] next_idx;
  } footer_t;
endpackage

interface memory_read_ctrl_if #(parameter int LEN_W = 16);
  import mem_pkg::*;

  logic                  desc_valid_i;
  logic                  desc_ready_o;
  logic [ADDR_W-1:0]     desc_head_idx_i;
  logic [LEN_W-1:0]      desc_len_i;
  logic                  mem_ready_i;
  logic                  mem_re_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic                  mem_rvalid_i;
  logic [BLOCK_BITS-1:0] mem_rdata_i;
  logic [7:0]            data_o;
  logic                  data_valid_o;
  logic                  data_begin_o;
  logic                  data_end_o;
  logic                  data_ready_i;
  logic                  fl_free_req_o;
  logic [ADDR_W-1:0]     fl_free_block_idx_o;
  logic                  fl_free_gnt_i;
  logic                  err_o;

  // Controller side
  modport slave (
    input  desc_valid_i, desc_head_idx_i, desc_len_i,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  data_ready_i, fl_free_gnt_i,
    output desc_ready_o, mem_re_o, mem_addr_o,
    output data_o, data_valid_o, data_begin_o, data_end_o,
    output fl_free_req_o, fl_free_block_idx_o, err_o
  );

  // Environment side (descriptor source, memory, TX sink, free list)
  modport master (
    output desc_valid_i, desc_head_idx_i, desc_len_i,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output data_ready_i, fl_free_gnt_i,
    input  desc_ready_o, mem_re_o, mem_addr_o,
    input  data_o, data_valid_o, data_begin_o, data_end_o,
    input  fl_free_req_o, fl_free_block_idx_o, err_o
  );
endinterface

// File: rtl/memory_read_ctrl.sv
// Egress read controller: walks a frame's linked block chain, streams the payload
// one byte per beat to the TX MAC and hands each drained block back to the free list.
module memory_read_ctrl
  import mem_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  memory_read_ctrl_if.slave bus
);

  localparam int PL_BITS = PAYLOAD_BYTES * 8;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STREAM, S_FREE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cur_idx_q, cur_idx_d;
  logic [ADDR_W-1:0]  next_idx_q, next_idx_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [PL_BITS-1:0] payload_q, payload_d;
  logic [5:0]         blk_bytes_q, blk_bytes_d;
  logic [5:0]         k_q, k_d;
  logic               first_q, first_d;
  logic               err_q, err_d;
  logic               ready_en_q, ready_en_d;

  footer_t            footer;
  logic               more_blocks;
  logic [8:0]         byte_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_idx_q   <= '0;
      next_idx_q  <= '0;
      remaining_q <= '0;
      payload_q   <= '0;
      blk_bytes_q <= '0;
      k_q         <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      next_idx_q  <= next_idx_d;
      remaining_q <= remaining_d;
      payload_q   <= payload_d;
      blk_bytes_q <= blk_bytes_d;
      k_q         <= k_d;
      first_q     <= first_d;
      err_q       <= err_d;
      ready_en_q  <= ready_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    next_idx_d  = next_idx_q;
    remaining_d = remaining_q;
    payload_d   = payload_q;
    blk_bytes_d = blk_bytes_q;
    k_d         = k_q;
    first_d     = first_q;
    err_d       = 1'b0;
    ready_en_d  = 1'b1;
    footer      = footer_t'(bus.mem_rdata_i[15:0]);
    more_blocks = remaining_q > LEN_W'(PAYLOAD_BYTES);

    // Read data nobody asked for is dropped but flagged.
    if (bus.mem_rvalid_i && state_q != S_WAIT) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.desc_valid_i && ready_en_q) begin
          if (bus.desc_len_i == '0) begin
            err_d = 1'b1;
          end else begin
            cur_idx_d   = bus.desc_head_idx_i;
            remaining_d = bus.desc_len_i;
            first_d     = 1'b1;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_rvalid_i) begin
          payload_d   = bus.mem_rdata_i[BLOCK_BITS-1:16];
          next_idx_d  = footer.next_idx;
          blk_bytes_d = more_blocks ? 6'(PAYLOAD_BYTES) : remaining_q[5:0];
          k_d         = '0;
          // The length decides the chain walk; eop is only cross-checked against it.
          if (footer.eop == more_blocks) err_d = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (bus.data_ready_i) begin
          remaining_d = remaining_q - LEN_W'(1);
          k_d         = k_q + 6'd1;
          if (k_q == blk_bytes_q - 6'd1) begin
            first_d = 1'b0;
            state_d = S_FREE;
          end
        end
      end
      S_FREE: begin
        if (bus.fl_free_gnt_i) begin
          if (remaining_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cur_idx_d = next_idx_q;
            state_d   = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.desc_ready_o        = (state_q == S_IDLE) && ready_en_q;
    bus.mem_re_o            = (state_q == S_REQ) && bus.mem_ready_i;
    bus.mem_addr_o          = (state_q == S_REQ) ? cur_idx_q : '0;
    bus.data_valid_o        = (state_q == S_STREAM);
    bus.data_o              = '0;
    bus.data_begin_o        = 1'b0;
    bus.data_end_o          = 1'b0;
    bus.fl_free_req_o       = (state_q == S_FREE);
    bus.fl_free_block_idx_o = (state_q == S_FREE) ? cur_idx_q : '0;
    bus.err_o               = err_q;
    // Bytes leave from the top of the block's valid region; a short final block
    // is right-aligned, so counting down from blk_bytes covers both cases.
    byte_lo = {6'(blk_bytes_q - 6'd1 - k_q), 3'b000};
    if (state_q == S_STREAM) begin
      bus.data_o       = payload_q[byte_lo +: 8];
      bus.data_begin_o = first_q && (k_q == '0);
      bus.data_end_o   = (remaining_q == LEN_W'(1));
    end
  end

endmodule
